// File: rtl/four_bit_signed_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the mini-calculator datapath.
//               - CALC_WIDTH : operand width (shared with the multiplier)
//               - div_state_e: divider FSM states
//               - c_DIV_ZERO_QUOT : quotient returned on divide-by-zero
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int CALC_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Truncated to the operand width at the point of use, giving all ones.
    localparam int signed c_DIV_ZERO_QUOT = -1;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/four_bit_signed_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_signed_divider_if
// Description : Start/done handshake and operand/result bundle of the signed
//               divider.
//   start                 request (master -> slave)
//   A, B                  dividend / divisor (master -> slave)
//   quotient, remainder   results (slave -> master)
//   busy, done            status / one-cycle completion pulse
//   div_by_zero, overflow flags for the last result
// Revision    : 1.0 - initial release
// ============================================================================
interface four_bit_signed_divider_if
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) ();

    logic                    start;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic signed [WIDTH-1:0] quotient;
    logic signed [WIDTH-1:0] remainder;
    logic                    busy;
    logic                    done;
    logic                    div_by_zero;
    logic                    overflow;

    modport master (
        output start, A, B,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, A, B,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );

endinterface : four_bit_signed_divider_if
`default_nettype wire

// File: rtl/four_bit_signed_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration on unsigned
//               magnitudes.
//   i_prem    [WIDTH:0] current partial remainder
//   i_divisor [WIDTH:0] divisor magnitude
//   i_bit               next dividend bit (MSB first)
//   o_prem    [WIDTH:0] next partial remainder
//   o_qbit              quotient bit produced by this iteration
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH:0] i_prem,
    input  wire logic [WIDTH:0] i_divisor,
    input  wire logic           i_bit,
    output logic      [WIDTH:0] o_prem,
    output logic                o_qbit
);

    // One extra bit so the shifted value can never wrap before the compare.
    logic [WIDTH+1:0] w_shifted;

    assign w_shifted = {i_prem, i_bit};
    assign o_qbit    = (w_shifted >= {1'b0, i_divisor});
    // Restoring form: keep the shifted value when the subtraction would go
    // negative. The kept value is always below 2*|B|, so it fits WIDTH+1 bits.
    assign o_prem    = o_qbit ? (WIDTH+1)'(w_shifted - {1'b0, i_divisor})
                              : w_shifted[WIDTH:0];

endmodule : div_step
`default_nettype wire

// File: rtl/four_bit_signed_divider.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_signed_divider
// Description : Sequential signed divider. Restoring shift-subtract on the
//               operand magnitudes (one bit per cycle, MSB first), followed
//               by a sign-fixup cycle. Truncates toward zero.
//   clk   rising-edge clock
//   rstn  synchronous active-low reset
//   bus   four_bit_signed_divider_if.slave (start/A/B in; quotient,
//         remainder, busy, done, div_by_zero, overflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module four_bit_signed_divider
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  wire logic                clk,
    input  wire logic                rstn,
    four_bit_signed_divider_if.slave bus
);

    localparam int                CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  c_LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  c_DBZ_QUOT  = WIDTH'(c_DIV_ZERO_QUOT);

    div_state_e              r_state;
    div_state_e              w_state_next;

    logic                    r_sign_a;
    logic                    r_sign_b;
    logic                    r_dbz;
    // Holds |A| on entry; each iteration shifts a dividend bit out of the top
    // and a quotient bit in at the bottom, so it ends as |quotient|.
    logic [WIDTH-1:0]        r_dvd;
    logic [WIDTH:0]          r_mag_b;
    logic [WIDTH:0]          r_prem;
    logic [CNT_W-1:0]        r_cnt;

    logic [WIDTH:0]          w_prem_next;
    logic                    w_qbit;
    logic [WIDTH-1:0]        w_mag_a;
    logic [WIDTH-1:0]        w_mag_b;
    logic [WIDTH-1:0]        w_rem_mag;
    logic signed [WIDTH-1:0] w_quot_fix;
    logic signed [WIDTH-1:0] w_rem_fix;
    logic                    w_ovf;

    logic signed [WIDTH-1:0] r_quot;
    logic signed [WIDTH-1:0] r_rem;
    logic                    r_done;
    logic                    r_dbz_flag;
    logic                    r_ovf;

    // |most-negative| = 2^(WIDTH-1) still fits WIDTH unsigned bits.
    assign w_mag_a = bus.A[WIDTH-1] ? $unsigned(-bus.A) : $unsigned(bus.A);
    assign w_mag_b = bus.B[WIDTH-1] ? $unsigned(-bus.B) : $unsigned(bus.B);

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_prem    (r_prem),
        .i_divisor (r_mag_b),
        .i_bit     (r_dvd[WIDTH-1]),
        .o_prem    (w_prem_next),
        .o_qbit    (w_qbit)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.B == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (r_cnt == c_LAST_ITER) begin
                    w_state_next = FIX;
                end
            end
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sign fixup
    // ------------------------------------------------------------------
    // On divide-by-zero no iteration ran, so r_dvd still holds |A| and the
    // same negate-if-A-negative rule rebuilds A as the remainder.
    assign w_rem_mag = r_dbz ? r_dvd : r_prem[WIDTH-1:0];
    // A positive-signed quotient whose magnitude has the MSB set can only be
    // most-negative / -1.
    assign w_ovf     = ~r_dbz & (r_sign_a == r_sign_b) & r_dvd[WIDTH-1];

    always_comb begin
        w_quot_fix = (r_sign_a ^ r_sign_b) ? -$signed(r_dvd) : $signed(r_dvd);
        if (r_dbz) begin
            w_quot_fix = $signed(c_DBZ_QUOT);
        end
        w_rem_fix = r_sign_a ? -$signed(w_rem_mag) : $signed(w_rem_mag);
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_dbz      <= 1'b0;
            r_dvd      <= '0;
            r_mag_b    <= '0;
            r_prem     <= '0;
            r_cnt      <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_done     <= 1'b0;
            r_dbz_flag <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sign_a <= bus.A[WIDTH-1];
                        r_sign_b <= bus.B[WIDTH-1];
                        r_dbz    <= (bus.B == '0);
                        r_dvd    <= w_mag_a;
                        r_mag_b  <= {1'b0, w_mag_b};
                        r_prem   <= '0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    r_prem <= w_prem_next;
                    r_dvd  <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt  <= r_cnt + 1'b1;
                end
                FIX: begin
                    r_quot     <= w_quot_fix;
                    r_rem      <= w_rem_fix;
                    r_dbz_flag <= r_dbz;
                    r_ovf      <= w_ovf;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz_flag;
    assign bus.overflow    = r_ovf;

endmodule : four_bit_signed_divider
`default_nettype wire

// File: tb/tb_four_bit_signed_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_bit_signed_divider
// Description : Self-checking bench for four_bit_signed_divider. A latency-
//               level model computes results with plain SV division; a
//               compare process checks every output on every cycle, and
//               directed operations pin literal results and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_bit_signed_divider;

    localparam int W = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    four_bit_signed_divider_if #(.WIDTH(W)) bus ();

    four_bit_signed_divider #(
        .WIDTH (W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: edges remaining until the result appears
    // ------------------------------------------------------------------
    int         m_left = 0;
    int         ma, mb, mq, mr;
    logic [3:0] p_q, p_r;
    logic       p_dbz, p_ov;
    logic [3:0] e_q = '0, e_r = '0;
    logic       e_dbz = 1'b0, e_ov = 1'b0, e_done = 1'b0, e_busy = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_left = 0;
            e_q    = '0;
            e_r    = '0;
            e_dbz  = 1'b0;
            e_ov   = 1'b0;
            e_done = 1'b0;
        end else begin
            e_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    e_q    = p_q;
                    e_r    = p_r;
                    e_dbz  = p_dbz;
                    e_ov   = p_ov;
                    e_done = 1'b1;
                end
            end else if (bus.start === 1'b1) begin
                ma = int'(bus.A);
                mb = int'(bus.B);
                p_dbz = 1'b0;
                p_ov  = 1'b0;
                if (mb == 0) begin
                    mq    = -1;
                    mr    = ma;
                    p_dbz = 1'b1;
                end else if (ma == -(2 ** (W - 1)) && mb == -1) begin
                    mq   = 2 ** (W - 1);
                    mr   = 0;
                    p_ov = 1'b1;
                end else begin
                    mq = ma / mb;
                    mr = ma % mb;
                end
                p_q    = 4'(mq);
                p_r    = 4'(mr);
                m_left = (mb == 0) ? 1 : W + 1;
            end
        end
        e_busy = (m_left > 0);
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            check("busy",      {7'h0, bus.busy},        {7'h0, e_busy});
            check("done",      {7'h0, bus.done},        {7'h0, e_done});
            check("quotient",  {4'h0, bus.quotient},    {4'h0, e_q});
            check("remainder", {4'h0, bus.remainder},   {4'h0, e_r});
            check("dbz",       {7'h0, bus.div_by_zero}, {7'h0, e_dbz});
            check("overflow",  {7'h0, bus.overflow},    {7'h0, e_ov});
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (literal expectations)
    // ------------------------------------------------------------------
    // Called at the first negedge after the accepting edge; returns how many
    // negedges (counting that one as 1) until done is seen.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 1;
        nbusy = 0;
        while (lat <= 20 && bus.done !== 1'b1) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        if (bus.done !== 1'b1) begin
            check("done_timeout", {7'h0, bus.done}, 8'h01);
        end
    endtask

    task automatic check_res(input string name, input logic [3:0] eq, input logic [3:0] er,
                             input logic edz, input logic eov);
        check({name, "_q"},   {4'h0, bus.quotient},    {4'h0, eq});
        check({name, "_r"},   {4'h0, bus.remainder},   {4'h0, er});
        check({name, "_dbz"}, {7'h0, bus.div_by_zero}, {7'h0, edz});
        check({name, "_ov"},  {7'h0, bus.overflow},    {7'h0, eov});
    endtask

    // Starts at a negedge with the DUT idle; returns at the done cycle.
    task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er,
                          input logic edz, input logic eov, input int elat);
        int lat, nb;
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 4'($urandom);
        bus.B     = 4'($urandom);
        wait_done(lat, nb);
        check({name, "_latency"}, 8'(lat), 8'(elat));
        check({name, "_busycyc"}, 8'(nb),  8'(elat - 1));
        check_res(name, eq, er, edz, eov);
    endtask

    int lat0, nb0, ndone;

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rstn      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {7'h0, bus.busy}, 8'h00);
        check("rst_done", {7'h0, bus.done}, 8'h00);
        check_res("rst", 4'h0, 4'h0, 1'b0, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic and sign combinations, issued back-to-back in the done cycle.
        run_op("7/2",    4'sd7,  4'sd2,  4'sd3,  4'sd1,  1'b0, 1'b0, 6);
        run_op("-7/2",  -4'sd7,  4'sd2, -4'sd3, -4'sd1,  1'b0, 1'b0, 6);
        run_op("7/-2",   4'sd7, -4'sd2, -4'sd3,  4'sd1,  1'b0, 1'b0, 6);
        run_op("-7/-2", -4'sd7, -4'sd2,  4'sd3, -4'sd1,  1'b0, 1'b0, 6);
        run_op("-8/3",   4'b1000, 4'sd3, -4'sd2, -4'sd2, 1'b0, 1'b0, 6);
        run_op("-8/-1",  4'b1000, -4'sd1, 4'b1000, 4'h0, 1'b0, 1'b1, 6);
        run_op("6/3",    4'sd6,  4'sd3,  4'sd2,  4'h0,   1'b0, 1'b0, 6);
        run_op("5/0",    4'sd5,  4'h0,  -4'sd1,  4'sd5,  1'b1, 1'b0, 2);
        run_op("0/-3",   4'h0,  -4'sd3,  4'h0,   4'h0,   1'b0, 1'b0, 6);

        // Start re-pulsed while busy is ignored.
        bus.start = 1'b1; bus.A = 4'sd7; bus.B = 4'sd2;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.A = -4'sd3; bus.B = 4'sd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat0, nb0);
        check_res("ignored", 4'sd3, 4'sd1, 1'b0, 1'b0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("ignored_extra_done", 8'(ndone), 8'h00);

        // Start held high through done: second op accepted immediately.
        bus.start = 1'b1; bus.A = 4'sd6; bus.B = 4'sd3;
        @(negedge clk);
        wait_done(lat0, nb0);
        check("held1_latency", 8'(lat0), 8'd6);
        check_res("held1", 4'sd2, 4'h0, 1'b0, 1'b0);
        bus.A = -4'sd7; bus.B = -4'sd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat0, nb0);
        check("held2_latency", 8'(lat0), 8'd6);
        check_res("held2", 4'sd3, -4'sd1, 1'b0, 1'b0);

        // Reset during CALC discards the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'sd3; bus.B = 4'sd1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("midrst_busy", {7'h0, bus.busy}, 8'h00);
        check("midrst_done", {7'h0, bus.done}, 8'h00);
        check_res("midrst", 4'h0, 4'h0, 1'b0, 1'b0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("midrst_no_done", 8'(ndone), 8'h00);
        run_op("-6/4", -4'sd6, 4'sd4, -4'sd1, -4'sd2, 1'b0, 1'b0, 6);

        // Random traffic, including starts while busy; the model tracks it.
        repeat (800) begin
            bus.start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                bus.A = 4'b1000;
                bus.B = 4'b1111;
            end else begin
                bus.A = 4'($urandom);
                bus.B = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_four_bit_signed_divider
`default_nettype wire
